// File: rtl/core_pkg.sv
// core_pkg: inst bundle field positions, idle bundle, sequencer states and
// the 11-bit memory address type shared by core_inst_seq and its interface.
package core_pkg;
    localparam int I_LOAD     = 0;
    localparam int I_EXEC     = 1;
    localparam int I_L0_WR    = 2;
    localparam int I_L0_RD    = 3;
    localparam int I_IFIFO_RD = 4;
    localparam int I_IFIFO_WR = 5;
    localparam int I_OFIFO_RD = 6;
    localparam int I_AX_LSB   = 7;
    localparam int I_WEN_X    = 18;
    localparam int I_CEN_X    = 19;
    localparam int I_AP_LSB   = 20;
    localparam int I_WEN_P    = 31;
    localparam int I_CEN_P    = 32;
    localparam int I_ACC      = 33;
    localparam int I_MODE     = 34;
    localparam logic [34:0] INST_IDLE = 35'h1_800C_0000;
    typedef logic [10:0] addr_t;
    typedef enum logic [2:0] {IDLE, WLOAD, WSETTLE, EXEC, FLUSH, PSUM, DRAIN} state_e;
endpackage

// File: rtl/core_inst_seq_if.sv
// core_inst_seq_if: host/core handshake of core_inst_seq.
// cycle_cnt exists only when CORE_INST_SEQ_PERF_EN is defined.
interface core_inst_seq_if;
    logic        start;
    logic        mode_w;
    logic        ofifo_valid;
    logic [34:0] inst;
    logic        busy;
    logic        done;
`ifdef CORE_INST_SEQ_PERF_EN
    logic [31:0] cycle_cnt;
    modport master (output start, mode_w, ofifo_valid, input inst, busy, done, cycle_cnt);
    modport slave (input start, mode_w, ofifo_valid, output inst, busy, done, cycle_cnt);
`else
    modport master (output start, mode_w, ofifo_valid, input inst, busy, done);
    modport slave (input start, mode_w, ofifo_valid, output inst, busy, done);
`endif
endinterface

// File: rtl/core_inst_seq_skew_pipe3.sv
// skew_pipe3: turns one issue flag into read / capture / fire strobes,
// each one cycle behind the previous (memory read latency, then capture).
module skew_pipe3 (
    input  logic clk,
    input  logic reset,
    input  logic issue_i,
    output logic rd_o,
    output logic cap_o,
    output logic fire_o
);
    logic [1:0] sr_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) sr_q <= '0;
        else       sr_q <= {sr_q[0], issue_i};
    assign rd_o   = issue_i;
    assign cap_o  = sr_q[0];
    assign fire_o = sr_q[1];
endmodule

// File: rtl/core_inst_seq.sv
// core_inst_seq: generates the 35-bit core inst bundle for a full convolution pass.
// Optional CORE_INST_SEQ_PERF_EN adds the saturating busy-cycle counter cycle_cnt.
module core_inst_seq import core_pkg::*; #(
    parameter int    ROW     = 8,
    parameter int    COL     = 8,
    parameter int    LEN_KIJ = 9,
    parameter int    LEN_NIJ = 36,
    parameter addr_t W_BASE  = 11'd1024,
    parameter addr_t A_BASE  = 11'd0,
    parameter addr_t P_BASE  = 11'd0
) (
    input logic clk,
    input logic reset,
    core_inst_seq_if.slave bus
);
    localparam int M1 = (2 * LEN_NIJ > ROW + COL) ? 2 * LEN_NIJ : ROW + COL;
    localparam int M2 = (M1 > COL + 2) ? M1 : COL + 2;
    localparam int M3 = (M2 > LEN_NIJ + 2) ? M2 : LEN_NIJ + 2;
    localparam int SW = $clog2(M3);
    localparam int KW = (LEN_KIJ > 1) ? $clog2(LEN_KIJ) : 1;
    localparam int PW = $clog2(LEN_NIJ + 1);
    localparam logic [SW-1:0] S_WL  = SW'(COL + 1);
    localparam logic [SW-1:0] S_WS  = SW'(COL - 1);
    localparam logic [SW-1:0] S_EX  = SW'(LEN_NIJ + 1);
    localparam logic [SW-1:0] S_FL  = SW'(ROW + COL - 1);
    localparam logic [SW-1:0] S_PS  = SW'(2 * LEN_NIJ - 1);
    localparam logic [SW-1:0] S_COL = SW'(COL);
    localparam logic [SW-1:0] S_NIJ = SW'(LEN_NIJ);
    localparam logic [KW-1:0] K_LAST = KW'(LEN_KIJ - 1);
    localparam logic [PW-1:0] P_LAST = PW'(LEN_NIJ);
    state_e state_q, state_d;
    logic [SW-1:0] step_q, step_d;
    logic [KW-1:0] kij_q, kij_d;
    logic [PW-1:0] pop_q, pop_d;
    logic mode_q, mode_d, busy_q, done_q, done_d;
    logic [34:0] inst_q, inst_d;
    logic wl, ex, issue, rd, cap, fire, ps_on, ps_wr, ofifo_rd;
    addr_t xa;
    always_comb begin
        state_d = state_q;
        step_d  = step_q + 1'b1;
        kij_d   = kij_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                step_d = '0;
                if (bus.start) begin
                    state_d = WLOAD;
                    kij_d   = '0;
                    mode_d  = bus.mode_w;
                end
            end
            WLOAD:   if (step_q == S_WL) begin state_d = WSETTLE; step_d = '0; end
            WSETTLE: if (step_q == S_WS) begin state_d = EXEC; step_d = '0; end
            EXEC:    if (step_q == S_EX) begin state_d = FLUSH; step_d = '0; end
            FLUSH:   if (step_q == S_FL) begin state_d = PSUM; step_d = '0; end
            PSUM: if (step_q == S_PS) begin
                state_d = (kij_q == K_LAST) ? DRAIN : WLOAD;
                step_d  = '0;
                kij_d   = kij_q + 1'b1;
            end
            DRAIN: begin
                step_d = '0;
                if (pop_q == P_LAST) begin state_d = IDLE; done_d = 1'b1; end
            end
            default: state_d = IDLE;
        endcase
    end
    // The bundle is built from next state so it lands in inst_q on the same edge.
    assign wl       = state_d == WLOAD;
    assign ex       = state_d == EXEC;
    assign issue    = (wl && step_d < S_COL) || (ex && step_d < S_NIJ);
    assign xa       = (wl ? W_BASE + addr_t'(kij_d) * addr_t'(COL) : A_BASE + addr_t'(kij_d) * addr_t'(LEN_NIJ)) + addr_t'(step_d);
    assign ps_wr    = state_d == PSUM && step_d[0];
    assign ps_on    = state_d == PSUM && (step_d[0] || kij_d != '0);
    assign ofifo_rd = state_d == DRAIN && bus.ofifo_valid;
    assign pop_d    = (state_q == IDLE) ? '0 : pop_q + PW'(ofifo_rd);
    skew_pipe3 u_skew (.clk(clk), .reset(reset), .issue_i(issue), .rd_o(rd), .cap_o(cap), .fire_o(fire));
    always_comb begin
        inst_d = INST_IDLE;
        inst_d[I_MODE]      = mode_d;
        inst_d[I_LOAD]      = wl & fire;
        inst_d[I_EXEC]      = ex & fire;
        inst_d[I_L0_WR]     = wl & cap;
        inst_d[I_L0_RD]     = 1'b0;
        inst_d[I_IFIFO_RD]  = 1'b0;
        inst_d[I_IFIFO_WR]  = ex & cap;
        inst_d[I_OFIFO_RD]  = ofifo_rd;
        inst_d[I_CEN_X]     = ~rd;
        inst_d[I_WEN_X]     = 1'b1;
        inst_d[I_AX_LSB+:11] = rd ? xa : '0;
        inst_d[I_CEN_P]     = ~ps_on;
        inst_d[I_WEN_P]     = ~ps_wr;
        inst_d[I_ACC]       = ps_wr;
        inst_d[I_AP_LSB+:11] = ps_on ? P_BASE + addr_t'(step_d[SW-1:1]) : '0;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            step_q  <= '0;
            kij_q   <= '0;
            pop_q   <= '0;
            mode_q  <= 1'b0;
            inst_q  <= INST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            kij_q   <= kij_d;
            pop_q   <= pop_d;
            mode_q  <= mode_d;
            inst_q  <= inst_d;
            busy_q  <= state_d != IDLE;
            done_q  <= done_d;
        end
    assign bus.inst = inst_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
`ifdef CORE_INST_SEQ_PERF_EN
    logic [31:0] cnt_q;
    always_ff @(posedge clk or posedge reset)
        if (reset)                              cnt_q <= '0;
        else if (state_q == IDLE && bus.start)  cnt_q <= '0;
        else if (busy_q && cnt_q != '1)         cnt_q <= cnt_q + 1'b1;
    assign bus.cycle_cnt = cnt_q;
`endif
endmodule
